// File: rtl/noc_arbiter.sv
// -----------------------------------------------------------------------------
// noc_arbiter
//
// Round-robin, packet-locked arbiter that lets one of four switch ranks at a
// time stream beats into a shared downstream FIFO. A grant is won in IDLE,
// held for the whole packet (until a beat carrying last_i), and then handed
// back through IDLE so there is always exactly one bubble cycle between
// grants. The round-robin pointer moves to the requester after the one that
// just finished, so a lone requester cannot starve the others.
//
// Optional feature (compile-time macro):
//   NOC_ARB_BURST_LIMIT_EN  - when defined, a 4-bit beat counter caps every
//                             grant at MAX_BURST beats. The beat that reaches
//                             the cap releases the grant even without last_i.
//                             When undefined there is no counter at all and a
//                             grant is only released by a last_i beat.
//
// Parameters:
//   NUM_REQ     number of requesters (this release supports exactly 4)
//   DATA_WIDTH  beat width in bits
//   MAX_BURST   beat cap per grant when the burst limit is enabled (1..15)
//
// Ports:
//   clk           in   single clock, all state updates on the rising edge
//   rst_n         in   asynchronous active-low reset
//   req_i         in   per-requester beat valid / request
//   last_i        in   per-requester "this beat ends the packet"
//   data_i        in   packed beats, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full_i   in   shared downstream FIFO is full, stalls beats
//   gnt_o         out  registered one-hot grant, zero while idle
//   fifo_wr_en_o  out  registered write strobe to the FIFO
//   fifo_data_o   out  registered write data, holds when no write
//   owner_o       out  index of the current (or most recent) owner
//   busy_o        out  high while a grant is held
// -----------------------------------------------------------------------------
module noc_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  input  logic                          fifo_full_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic [1:0]                    owner_o,
  output logic                          busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_stateNext;

  logic [NUM_REQ-1:0]     r_gnt;
  logic [1:0]             r_owner;
  logic [1:0]             r_rrPtr;
  logic                   r_wrEn;
  logic [DATA_WIDTH-1:0]  r_data;

  logic [NUM_REQ-1:0]     w_gntNext;
  logic [1:0]             w_ownerNext;
  logic [1:0]             w_rrPtrNext;
  logic                   w_wrEnNext;
  logic [DATA_WIDTH-1:0]  w_dataNext;

  logic                   w_anyReq;
  logic [1:0]             w_pickIdx;
  logic                   w_pickFound;
  logic [DATA_WIDTH-1:0]  w_ownerData;
  logic                   w_beat;
  logic                   w_burstDone;
  logic                   w_release;

  assign w_anyReq = |req_i;

  // Round-robin pick: walk the request vector starting at the pointer and
  // wrapping modulo 4 (the 2-bit add wraps for free). The first requester
  // found wins; the found flag keeps later hits from overriding it.
  always_comb begin
    w_pickIdx   = r_rrPtr;
    w_pickFound = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_pickFound && req_i[r_rrPtr + 2'(i)]) begin
        w_pickIdx   = r_rrPtr + 2'(i);
        w_pickFound = 1'b1;
      end
    end
  end

  // Select the owner's slice of the packed data bus. A constant-index mux
  // keeps the part-select widths trivially clean.
  always_comb begin
    w_ownerData = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_owner == 2'(k)) begin
        w_ownerData = data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A beat only moves while we hold a grant, the owner is actually
  // presenting data and the FIFO can take it. Requests from anyone else
  // are simply not looked at here.
  assign w_beat = (r_state == GRANT) && req_i[r_owner] && !fifo_full_i;

`ifdef NOC_ARB_BURST_LIMIT_EN
  logic [3:0] r_beatCnt;
  logic [3:0] w_beatCntNext;

  assign w_beatCntNext = r_beatCnt + 4'd1;
  assign w_burstDone   = (w_beatCntNext == 4'(MAX_BURST));

  // Beat counter: restarts whenever a new grant is handed out and counts
  // accepted beats only, so stalls and dropped requests do not use up the
  // burst allowance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beatCnt <= 4'd0;
    end else if (r_state == IDLE && w_anyReq) begin
      r_beatCnt <= 4'd0;
    end else if (w_beat) begin
      r_beatCnt <= w_beatCntNext;
    end
  end
`else
  assign w_burstDone = 1'b0;
`endif

  // The grant ends on the beat that carries last_i, or on the beat that
  // uses up the burst allowance when that limit is built in.
  assign w_release = w_beat && (last_i[r_owner] || w_burstDone);

  // State register. Reset drops straight back to IDLE, abandoning any
  // packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. IDLE always lasts at least one cycle after a release,
  // which is what produces the single bubble between grants.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_stateNext = GRANT;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Output logic: next values for the registered outputs. Owner and write
  // data hold by default so owner_o still names the last owner after a
  // release and fifo_data_o keeps the last written beat.
  always_comb begin
    w_gntNext   = r_gnt;
    w_ownerNext = r_owner;
    w_rrPtrNext = r_rrPtr;
    w_wrEnNext  = 1'b0;
    w_dataNext  = r_data;
    case (r_state)
      IDLE: begin
        w_gntNext = '0;
        if (w_anyReq) begin
          w_gntNext[w_pickIdx] = 1'b1;
          w_ownerNext          = w_pickIdx;
        end
      end
      GRANT: begin
        if (w_beat) begin
          w_wrEnNext = 1'b1;
          w_dataNext = w_ownerData;
        end
        if (w_release) begin
          w_gntNext   = '0;
          w_rrPtrNext = r_owner + 2'd1;
        end
      end
      default: begin
        w_gntNext = '0;
      end
    endcase
  end

  // Output and pointer registers. Everything visible at the ports comes
  // straight from a flop so downstream timing never sees the arbitration
  // logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt   <= '0;
      r_owner <= 2'd0;
      r_rrPtr <= 2'd0;
      r_wrEn  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_gnt   <= w_gntNext;
      r_owner <= w_ownerNext;
      r_rrPtr <= w_rrPtrNext;
      r_wrEn  <= w_wrEnNext;
      r_data  <= w_dataNext;
    end
  end

  assign gnt_o        = r_gnt;
  assign fifo_wr_en_o = r_wrEn;
  assign fifo_data_o  = r_data;
  assign owner_o      = r_owner;
  assign busy_o       = (r_state == GRANT);

endmodule

// File: tb/tb_noc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_arbiter
//
// Self-checking bench for noc_arbiter. Directed scenarios check reset,
// latency, round robin, backpressure, packet lock, burst limit and async
// reset against fixed expected values; a randomized run compares every
// output each cycle against a behavioural model that tracks "who owns the
// bus, if anyone" plus the round-robin pointer as plain integers.
// Honours NOC_ARB_BURST_LIMIT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_noc_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ-1:0]            last_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_i;
  logic                          fifo_full_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic                          fifo_wr_en_o;
  logic [DATA_WIDTH-1:0]         fifo_data_o;
  logic [1:0]                    owner_o;
  logic                          busy_o;

  int total = 0;
  int bad   = 0;

  // Reference model state: owner index or -1 when idle, pointer, beat count
  int mOwner;
  int mPtr;
  int mCnt;
  logic [3:0] eGnt;
  logic       eWr;
  logic [7:0] eData;
  logic [1:0] eOwner;
  logic       eBusy;

  noc_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .last_i      (last_i),
    .data_i      (data_i),
    .fifo_full_i (fifo_full_i),
    .gnt_o       (gnt_o),
    .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_data_o (fifo_data_o),
    .owner_o     (owner_o),
    .busy_o      (busy_o)
  );

  // Free-running 10-time-unit clock
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic logic [31:0] packSlot(input int k, input logic [7:0] v);
    logic [31:0] d;
    d = $urandom;
    d[k*8 +: 8] = v;
    return d;
  endfunction

  task automatic modelReset();
    mOwner = -1;
    mPtr   = 0;
    mCnt   = 0;
    eGnt   = 4'b0;
    eWr    = 1'b0;
    eData  = 8'h00;
    eOwner = 2'd0;
    eBusy  = 1'b0;
  endtask

  // One clock of arbiter behaviour: what the outputs should be after the
  // next rising edge, given the inputs presented during this cycle.
  task automatic modelStep(input logic [3:0] req, input logic [3:0] last,
                           input logic [31:0] data, input logic full);
    int pick;
    bit burstHit;
    eWr = 1'b0;
    if (mOwner < 0) begin
      if (req != 4'b0) begin
        pick = -1;
        for (int k = 0; k < 4; k++) begin
          if (pick < 0 && req[(mPtr + k) % 4]) pick = (mPtr + k) % 4;
        end
        mOwner = pick;
        mCnt   = 0;
      end
    end else if (req[mOwner] && !full) begin
      eWr   = 1'b1;
      eData = data[mOwner*8 +: 8];
      mCnt  = mCnt + 1;
      burstHit = 1'b0;
`ifdef NOC_ARB_BURST_LIMIT_EN
      burstHit = (mCnt == MAX_BURST);
`endif
      if (last[mOwner] || burstHit) begin
        mPtr   = (mOwner + 1) % 4;
        mOwner = -1;
      end
    end
    eBusy = (mOwner >= 0);
    eGnt  = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0;
    if (mOwner >= 0) eOwner = 2'(mOwner);
  endtask

  // Present one cycle of inputs, advance the model, then land 1 unit after
  // the rising edge where the registered outputs are stable.
  task automatic driveCycle(input logic [3:0] req, input logic [3:0] last,
                            input logic [31:0] data, input logic full);
    req_i       = req;
    last_i      = last;
    data_i      = data;
    fifo_full_i = full;
    modelStep(req, last, data, full);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n       = 1'b0;
    req_i       = '0;
    last_i      = '0;
    data_i      = '0;
    fifo_full_i = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reset values appear without a clock edge and stay put while reset is held
  task automatic test_reset();
    rst_n = 1'b1;
    req_i = '0; last_i = '0; data_i = '0; fifo_full_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (gnt_o !== 4'b0) begin bad++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt_o); end
    total++; if (fifo_wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr: got %b expected 0", fifo_wr_en_o); end
    total++; if (fifo_data_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h expected 00", fifo_data_o); end
    total++; if (owner_o !== 2'd0) begin bad++; $display("[TB] FAIL reset_owner: got %0d expected 0", owner_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    req_i = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    total++; if (gnt_o !== 4'b0) begin bad++; $display("[TB] FAIL reset_hold_gnt: got %b expected 0000", gnt_o); end
    doReset();
  endtask

  // Three-beat packet from requester 0: grant at t+1, writes t+2..t+4
  task automatic test_single();
    doReset();
    driveCycle(4'b0001, 4'b0000, packSlot(0, 8'h11), 1'b0);
    total++; if (gnt_o !== 4'b0001) begin bad++; $display("[TB] FAIL single_gnt: got %b expected 0001", gnt_o); end
    total++; if (fifo_wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL single_wr_t1: got %b expected 0", fifo_wr_en_o); end
    driveCycle(4'b0001, 4'b0000, packSlot(0, 8'h11), 1'b0);
    total++; if (fifo_wr_en_o !== 1'b1 || fifo_data_o !== 8'h11) begin bad++; $display("[TB] FAIL single_beat1: got wr=%b data=%h expected wr=1 data=11", fifo_wr_en_o, fifo_data_o); end
    driveCycle(4'b0001, 4'b0000, packSlot(0, 8'h22), 1'b0);
    total++; if (fifo_wr_en_o !== 1'b1 || fifo_data_o !== 8'h22) begin bad++; $display("[TB] FAIL single_beat2: got wr=%b data=%h expected wr=1 data=22", fifo_wr_en_o, fifo_data_o); end
    driveCycle(4'b0001, 4'b0001, packSlot(0, 8'h33), 1'b0);
    total++; if (fifo_wr_en_o !== 1'b1 || fifo_data_o !== 8'h33) begin bad++; $display("[TB] FAIL single_beat3: got wr=%b data=%h expected wr=1 data=33", fifo_wr_en_o, fifo_data_o); end
    total++; if (gnt_o !== 4'b0000 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL single_release: got gnt=%b busy=%b expected gnt=0000 busy=0", gnt_o, busy_o); end
    driveCycle(4'b0000, 4'b0000, 32'h0, 1'b0);
    total++; if (gnt_o !== 4'b0000 || fifo_wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL single_after: got gnt=%b wr=%b expected gnt=0000 wr=0", gnt_o, fifo_wr_en_o); end
    total++; if (owner_o !== 2'd0) begin bad++; $display("[TB] FAIL single_owner_hold: got %0d expected 0", owner_o); end
  endtask

  // Everyone requesting with one-beat packets: owners 0,1,2,3,0 with a bubble
  task automatic test_round_robin();
    doReset();
    for (int g = 0; g < 5; g++) begin
      driveCycle(4'b1111, 4'b1111, $urandom, 1'b0);
      total++; if (gnt_o !== 4'(1 << (g % 4)) || owner_o !== 2'(g % 4)) begin bad++; $display("[TB] FAIL rr_grant%0d: got gnt=%b owner=%0d expected owner=%0d", g, gnt_o, owner_o, g % 4); end
      driveCycle(4'b1111, 4'b1111, $urandom, 1'b0);
      total++; if (gnt_o !== 4'b0 || busy_o !== 1'b0 || fifo_wr_en_o !== 1'b1) begin bad++; $display("[TB] FAIL rr_bubble%0d: got gnt=%b busy=%b wr=%b expected 0000/0/1", g, gnt_o, busy_o, fifo_wr_en_o); end
    end
  endtask

  // FIFO full for three cycles mid-packet: no writes, grant held, data kept
  task automatic test_backpressure();
    doReset();
    driveCycle(4'b0100, 4'b0000, packSlot(2, 8'hA0), 1'b0);
    total++; if (gnt_o !== 4'b0100) begin bad++; $display("[TB] FAIL bp_gnt: got %b expected 0100", gnt_o); end
    driveCycle(4'b0100, 4'b0000, packSlot(2, 8'hA1), 1'b0);
    total++; if (fifo_wr_en_o !== 1'b1 || fifo_data_o !== 8'hA1) begin bad++; $display("[TB] FAIL bp_beat1: got wr=%b data=%h expected wr=1 data=a1", fifo_wr_en_o, fifo_data_o); end
    for (int s = 0; s < 3; s++) begin
      driveCycle(4'b0100, 4'b0000, packSlot(2, 8'hA2), 1'b1);
      total++; if (fifo_wr_en_o !== 1'b0 || gnt_o !== 4'b0100 || busy_o !== 1'b1 || fifo_data_o !== 8'hA1) begin bad++; $display("[TB] FAIL bp_stall%0d: got wr=%b gnt=%b busy=%b data=%h expected 0/0100/1/a1", s, fifo_wr_en_o, gnt_o, busy_o, fifo_data_o); end
    end
    driveCycle(4'b0100, 4'b0000, packSlot(2, 8'hA2), 1'b0);
    total++; if (fifo_wr_en_o !== 1'b1 || fifo_data_o !== 8'hA2) begin bad++; $display("[TB] FAIL bp_beat2: got wr=%b data=%h expected wr=1 data=a2", fifo_wr_en_o, fifo_data_o); end
    driveCycle(4'b0100, 4'b0100, packSlot(2, 8'hA3), 1'b0);
    total++; if (fifo_wr_en_o !== 1'b1 || fifo_data_o !== 8'hA3 || gnt_o !== 4'b0) begin bad++; $display("[TB] FAIL bp_beat3: got wr=%b data=%h gnt=%b expected 1/a3/0000", fifo_wr_en_o, fifo_data_o, gnt_o); end
  endtask

  // Owner drops its request without last: grant kept, others ignored
  task automatic test_packet_lock();
    doReset();
    driveCycle(4'b0010, 4'b0000, packSlot(1, 8'h70), 1'b0);
    total++; if (gnt_o !== 4'b0010) begin bad++; $display("[TB] FAIL lock_gnt: got %b expected 0010", gnt_o); end
    for (int s = 0; s < 2; s++) begin
      driveCycle(4'b1101, 4'b1111, $urandom, 1'b0);
      total++; if (gnt_o !== 4'b0010 || fifo_wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL lock_hold%0d: got gnt=%b wr=%b expected 0010/0", s, gnt_o, fifo_wr_en_o); end
    end
    driveCycle(4'b0010, 4'b0010, packSlot(1, 8'h77), 1'b0);
    total++; if (fifo_wr_en_o !== 1'b1 || fifo_data_o !== 8'h77 || gnt_o !== 4'b0) begin bad++; $display("[TB] FAIL lock_last: got wr=%b data=%h gnt=%b expected 1/77/0000", fifo_wr_en_o, fifo_data_o, gnt_o); end
    driveCycle(4'b1101, 4'b0000, $urandom, 1'b0);
    total++; if (gnt_o !== 4'b0100 || owner_o !== 2'd2) begin bad++; $display("[TB] FAIL lock_next: got gnt=%b owner=%0d expected 0100/2", gnt_o, owner_o); end
  endtask

  // Requester 2 streams six beats with no last; requester 3 also waiting
  task automatic test_burst_limit();
    doReset();
    driveCycle(4'b0100, 4'b0000, $urandom, 1'b0);
    total++; if (gnt_o !== 4'b0100) begin bad++; $display("[TB] FAIL burst_gnt: got %b expected 0100", gnt_o); end
`ifdef NOC_ARB_BURST_LIMIT_EN
    for (int b = 1; b <= 4; b++) begin
      driveCycle(4'b1100, 4'b0000, packSlot(2, 8'(8'h30 + b)), 1'b0);
      total++; if (fifo_wr_en_o !== 1'b1 || fifo_data_o !== 8'(8'h30 + b)) begin bad++; $display("[TB] FAIL burst_beat%0d: got wr=%b data=%h expected wr=1 data=%h", b, fifo_wr_en_o, fifo_data_o, 8'(8'h30 + b)); end
      total++; if (gnt_o !== ((b == 4) ? 4'b0000 : 4'b0100)) begin bad++; $display("[TB] FAIL burst_gnt%0d: got %b expected %b", b, gnt_o, (b == 4) ? 4'b0000 : 4'b0100); end
    end
    driveCycle(4'b1100, 4'b0000, $urandom, 1'b0);
    total++; if (gnt_o !== 4'b1000 || owner_o !== 2'd3) begin bad++; $display("[TB] FAIL burst_next: got gnt=%b owner=%0d expected 1000/3", gnt_o, owner_o); end
`else
    for (int b = 1; b <= 6; b++) begin
      driveCycle(4'b1100, 4'b0000, packSlot(2, 8'(8'h30 + b)), 1'b0);
      total++; if (fifo_wr_en_o !== 1'b1 || fifo_data_o !== 8'(8'h30 + b) || gnt_o !== 4'b0100) begin bad++; $display("[TB] FAIL nolimit_beat%0d: got wr=%b data=%h gnt=%b expected 1/%h/0100", b, fifo_wr_en_o, fifo_data_o, gnt_o, 8'(8'h30 + b)); end
    end
    driveCycle(4'b1100, 4'b0100, packSlot(2, 8'h3F), 1'b0);
    total++; if (gnt_o !== 4'b0000) begin bad++; $display("[TB] FAIL nolimit_release: got %b expected 0000", gnt_o); end
`endif
  endtask

  // Reset asserted between edges mid-packet clears outputs immediately
  task automatic test_async_reset();
    doReset();
    driveCycle(4'b0010, 4'b0000, $urandom, 1'b0);
    driveCycle(4'b0010, 4'b0000, packSlot(1, 8'h5A), 1'b0);
    total++; if (fifo_wr_en_o !== 1'b1 || gnt_o !== 4'b0010) begin bad++; $display("[TB] FAIL ar_pre: got wr=%b gnt=%b expected 1/0010", fifo_wr_en_o, gnt_o); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (gnt_o !== 4'b0 || fifo_wr_en_o !== 1'b0 || fifo_data_o !== 8'h00 || owner_o !== 2'd0 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL ar_clear: got gnt=%b wr=%b data=%h owner=%0d busy=%b expected all zero", gnt_o, fifo_wr_en_o, fifo_data_o, owner_o, busy_o); end
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    driveCycle(4'b1000, 4'b0000, $urandom, 1'b0);
    total++; if (gnt_o !== 4'b1000 || owner_o !== 2'd3) begin bad++; $display("[TB] FAIL ar_regrant: got gnt=%b owner=%0d expected 1000/3", gnt_o, owner_o); end
  endtask

  // Random traffic compared cycle by cycle against the model
  task automatic test_random();
    logic [3:0] req;
    logic [3:0] last;
    logic       full;
    doReset();
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 4; k++) begin
        req[k]  = ($urandom_range(0, 9) < ((c < 1000) ? 6 : 2));
        last[k] = ($urandom_range(0, 9) < 3);
      end
      full = ($urandom_range(0, 9) < 2);
      driveCycle(req, last, $urandom, full);
      total++; if (gnt_o !== eGnt) begin bad++; $display("[TB] FAIL rnd_gnt c%0d: got %b expected %b", c, gnt_o, eGnt); end
      total++; if (fifo_wr_en_o !== eWr) begin bad++; $display("[TB] FAIL rnd_wr c%0d: got %b expected %b", c, fifo_wr_en_o, eWr); end
      total++; if (fifo_data_o !== eData) begin bad++; $display("[TB] FAIL rnd_data c%0d: got %h expected %h", c, fifo_data_o, eData); end
      total++; if (owner_o !== eOwner) begin bad++; $display("[TB] FAIL rnd_owner c%0d: got %0d expected %0d", c, owner_o, eOwner); end
      total++; if (busy_o !== eBusy) begin bad++; $display("[TB] FAIL rnd_busy c%0d: got %b expected %b", c, busy_o, eBusy); end
    end
  endtask

  initial begin
    $display("[TB] starting noc_arbiter bench");
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_packet_lock();
    test_burst_limit();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
